// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, WIDTH cycles per result.
// Optional signed-overflow output o_overflow when SERIAL_SUB_OVF_EN is defined.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             o_overflow
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bin_q, bin_d;
  logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             ovf_q, ovf_d;
`endif

  // Full-subtractor cell on the current LSBs.
  logic fs_d;
  logic fs_bout;
  assign fs_d    = a_q[0] ^ b_q[0] ^ bin_q;
  assign fs_bout = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bin_q);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    sa_d     = sa_q;
    sb_d     = sb_q;
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = i_a;
          b_d     = i_b;
          res_d   = '0;
          bin_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
          sa_d    = i_a[WIDTH-1];
          sb_d    = i_b[WIDTH-1];
`endif
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        bin_d = fs_bout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: publish result and final borrow on the edge that enters DONE.
          state_d  = S_DONE;
          diff_d   = {fs_d, res_q[WIDTH-1:1]};
          borrow_d = fs_bout;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = (sa_q != sb_q) && (fs_d != sa_q);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_ready  = (state_q == S_IDLE);
  assign o_busy   = (state_q == S_SHIFT);
  assign o_done   = (state_q == S_DONE);
  assign o_diff   = diff_q;
  assign o_borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
  assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); overflow vectors run when SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             i_reset;
  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_ready;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_diff;
  logic             o_borrow;
`ifdef SERIAL_SUB_OVF_EN
  logic             o_overflow;
`endif

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_start   (i_start),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_diff    (o_diff),
    .o_borrow  (o_borrow)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .o_overflow(o_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_start = 1'b0; i_a = '0; i_b = '0;
    tick(); tick();
    i_reset = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b100) begin
      errors++; $display("FAIL reset_flags: got %b expected 100", {o_ready, o_busy, o_done});
    end
    checks++;
    if (o_diff !== 8'h00 || o_borrow !== 1'b0) begin
      errors++; $display("FAIL reset_result: got %h/%b expected 00/0", o_diff, o_borrow);
    end
  endtask

  // Starts one subtraction, scrambles the inputs after capture, checks latency and result.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] exp_d, input logic exp_b, input string name);
    int cyc;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready_before: got %b expected 1", name, o_ready);
    end
    i_start = 1'b1; i_a = a; i_b = b;
    tick();
    i_start = 1'b0; i_a = ~a; i_b = a ^ 8'h5A;
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 40) begin
      checks++;
      if ({1'b0, o_ready} + {1'b0, o_busy} + {1'b0, o_done} !== 2'd1) begin
        errors++; $display("FAIL %s_exclusive: got %b%b%b expected one-hot", name, o_ready, o_busy, o_done);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != WIDTH + 1) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, WIDTH + 1);
    end
    checks++;
    if (o_diff !== exp_d || o_borrow !== exp_b) begin
      errors++; $display("FAIL %s_result: got %h/%b expected %h/%b", name, o_diff, o_borrow, exp_d, exp_b);
    end
    tick();
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b100 || o_diff !== exp_d) begin
      errors++; $display("FAIL %s_after: got %b%b%b diff %h expected 100 diff %h",
                         name, o_ready, o_busy, o_done, o_diff, exp_d);
    end
  endtask

  task automatic test_basic();
    run_op(8'h05, 8'h03, 8'h02, 1'b0, "sub_05_03");
    run_op(8'h00, 8'h01, 8'hFF, 1'b1, "sub_00_01");
    run_op(8'hA5, 8'hA5, 8'h00, 1'b0, "sub_A5_A5");
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, "sub_03_05");
    run_op(8'hFF, 8'h00, 8'hFF, 1'b0, "sub_FF_00");
    run_op(8'h3C, 8'hC3, 8'h79, 1'b1, "sub_3C_C3");
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_overflow();
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, "ovf_80_01");
    checks++;
    if (o_overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_80_01_flag: got %b expected 1", o_overflow);
    end
    run_op(8'h7F, 8'h01, 8'h7E, 1'b0, "ovf_7F_01");
    checks++;
    if (o_overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_7F_01_flag: got %b expected 0", o_overflow);
    end
  endtask
`endif

  task automatic test_ignore_start();
    int dones;
    logic [7:0] seen;
    dones = 0;
    seen  = 8'hXX;
    i_start = 1'b1; i_a = 8'h10; i_b = 8'h01;
    tick();                       // first SHIFT cycle
    i_start = 1'b0;
    tick(); tick();               // third SHIFT cycle
    i_start = 1'b1; i_a = 8'h00; i_b = 8'h00;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done === 1'b1) begin
        dones++;
        seen = o_diff;
      end
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++; $display("FAIL ignore_start_dones: got %0d expected 1", dones);
    end
    checks++;
    if (seen !== 8'h0F) begin
      errors++; $display("FAIL ignore_start_diff: got %h expected 0F", seen);
    end
  endtask

  task automatic test_reset_abort();
    int dones;
    dones = 0;
    i_start = 1'b1; i_a = 8'h05; i_b = 8'h03;
    tick();                       // first SHIFT cycle
    i_start = 1'b0;
    tick(); tick(); tick();       // fourth SHIFT cycle
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b100 || o_diff !== 8'h00 || o_borrow !== 1'b0) begin
      errors++; $display("FAIL abort_state: got %b%b%b diff %h borrow %b expected 100 diff 00 borrow 0",
                         o_ready, o_busy, o_done, o_diff, o_borrow);
    end
    for (int i = 0; i < 20; i++) begin
      if (o_done === 1'b1) dones++;
      tick();
    end
    checks++;
    if (dones != 0) begin
      errors++; $display("FAIL abort_no_done: got %0d expected 0", dones);
    end
    // Reset wins over a simultaneous start.
    i_reset = 1'b1; i_start = 1'b1; i_a = 8'h09; i_b = 8'h02;
    tick();
    i_reset = 1'b0; i_start = 1'b0;
    checks++;
    if ({o_ready, o_busy, o_done} !== 3'b100) begin
      errors++; $display("FAIL reset_priority: got %b expected 100", {o_ready, o_busy, o_done});
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, "b2b_first");
    // run_op returns in the first cycle o_ready is high again.
    i_start = 1'b1; i_a = 8'h20; i_b = 8'h07;
    tick();
    i_start = 1'b0; i_a = 8'hFF; i_b = 8'hFF;
    cyc = 1;
    while (o_done !== 1'b1 && cyc < 40) begin
      checks++;
      if (o_diff !== 8'hFE || o_borrow !== 1'b1) begin
        errors++; $display("FAIL b2b_hold: got %h/%b expected FE/1 at cycle %0d", o_diff, o_borrow, cyc);
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != WIDTH + 1) begin
      errors++; $display("FAIL b2b_latency: got %0d expected %0d", cyc, WIDTH + 1);
    end
    checks++;
    if (o_diff !== 8'h19 || o_borrow !== 1'b0) begin
      errors++; $display("FAIL b2b_second: got %h/%b expected 19/0", o_diff, o_borrow);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
`ifdef SERIAL_SUB_OVF_EN
    test_overflow();
`endif
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_reset  input  1  synchronous, active-high reset.
REQ-004 i_start  input  1  request to begin one subtraction; sampled only when o_ready=1.
REQ-005 i_a  input  WIDTH  minuend, captured on an accepted start.
REQ-006 i_b  input  WIDTH  subtrahend, captured on an accepted start.
REQ-007 o_ready  output  1  high while in IDLE; start accepted only then.
REQ-008 o_busy  output  1  high while bits are being processed (SHIFT).
REQ-009 o_done  output  1  one-cycle pulse when the result is valid.
REQ-010 o_diff  output  WIDTH  result i_a - i_b modulo 2^WIDTH; held until next done.
REQ-011 o_borrow  output  1  final borrow; 1 iff i_a < i_b unsigned; held with o_diff.

Function
REQ-012 FSM states IDLE, SHIFT, DONE; encoding is free.
REQ-013 IDLE: o_ready=1; i_start=1 -> capture i_a, i_b into shift registers, clear internal borrow and bit counter, go to SHIFT.
REQ-014 IDLE: i_start=0 -> stay in IDLE.
REQ-015 SHIFT: one bit per cycle, LSB first, through a single full-subtractor cell: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
REQ-016 SHIFT: d shifts into the result register MSB side; bout becomes bin for the next bit.
REQ-017 SHIFT lasts exactly WIDTH cycles, then go to DONE.
REQ-018 Entering DONE loads o_diff and o_borrow from the result register and final borrow, in the same edge that asserts o_done.
REQ-019 DONE lasts one cycle with o_done=1, then returns to IDLE unconditionally.
REQ-020 Latency: start accepted at edge N -> o_done high in the cycle after edge N+WIDTH -> o_ready high again after edge N+WIDTH+1.
REQ-021 i_start in SHIFT or DONE is ignored; it is not queued, and operands are not recaptured.
REQ-022 Changes on i_a/i_b after capture do not affect the current result.
REQ-023 o_diff and o_borrow change only on entry to DONE or on reset.
REQ-024 o_ready, o_busy and o_done are mutually exclusive; exactly one is high in every cycle after reset.

Reset
REQ-025 i_reset=1 at an edge forces IDLE: o_ready=1, o_busy=0, o_done=0, o_diff=0, o_borrow=0, internal registers and counter cleared.
REQ-026 Reset in SHIFT or DONE aborts the operation; no o_done pulse follows.
REQ-027 Reset has priority over i_start at the same edge.

Configuration
REQ-028 Macro SERIAL_SUB_OVF_EN defined: add output o_overflow (1 bit, signed two's-complement overflow = sign(a)!=sign(b) and sign(diff)!=sign(a)); updated and held exactly like o_diff; reset value 0.
REQ-029 Macro SERIAL_SUB_OVF_EN not defined: port o_overflow and its logic are absent; all other behaviour is identical.

Verification
REQ-030 WIDTH=8, reset, start with a=8'h05, b=8'h03 -> o_done exactly 9 cycles after the start edge, o_diff=8'h02, o_borrow=0.
REQ-031 a=8'h00, b=8'h01 -> o_diff=8'hFF, o_borrow=1; a=8'hA5, b=8'hA5 -> o_diff=8'h00, o_borrow=0.
REQ-032 With SERIAL_SUB_OVF_EN: a=8'h80, b=8'h01 -> o_diff=8'h7F, o_borrow=0, o_overflow=1; a=8'h7F, b=8'h01 -> o_overflow=0.
REQ-033 Start (8'h10-8'h01), then pulse i_start with a=8'h00, b=8'h00 on the 3rd SHIFT cycle -> ignored; single o_done, o_diff=8'h0F.
REQ-034 Start, assert i_reset on the 4th SHIFT cycle -> next cycle o_ready=1 and all outputs 0; no o_done pulse within 20 cycles.
REQ-035 Back-to-back: raise i_start in the first cycle o_ready is high again -> second result correct; previous o_diff is held until the second o_done.
